parse_ctrl: RTL and testbench
=============================

PARSE_CTRL -- requirements
Module: parse_ctrl

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 16, width of packet byte offsets and packet length.
REQ-002 SHALL provide parameter LEN_WIDTH, default 8, width of one header-length entry.
REQ-003 SHALL provide parameter NUM_HEADERS, default 4, number of header-length table entries; IDX_WIDTH = clog2(NUM_HEADERS), default 2.
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous reset, active-high.
REQ-007 cfg_we  input  1  header-length table write strobe.
REQ-008 cfg_idx  input  IDX_WIDTH  table entry to write.
REQ-009 cfg_len  input  LEN_WIDTH  header length in bytes to write.
REQ-010 pkt_valid  input  1  new packet available for parsing.
REQ-011 pkt_len  input  ADDR_WIDTH  packet length in bytes, sampled on accept.
REQ-012 pkt_ready  output  1  controller can accept a packet.
REQ-013 hdr_valid  output  1  one-cycle strobe, hdr_idx/hdr_addr_o valid.
REQ-014 hdr_idx  output  IDX_WIDTH  index of header just located.
REQ-015 hdr_addr_o  output  ADDR_WIDTH  byte offset of that header in the packet.
REQ-016 done  output  1  one-cycle pulse, walk finished.
REQ-017 err  output  1  qualified by done; walk stopped on a header overrunning the packet.
REQ-018 hdr_cnt  output  IDX_WIDTH+1  headers emitted in the last walk, valid with done.

Function
REQ-019 FSM states IDLE, WALK, DONE; pkt_ready SHALL be 1 exactly when state is IDLE.
REQ-020 Accept = pkt_valid & pkt_ready at a rising edge: latch pkt_len, offset<=0, idx<=0, cnt<=0, go to WALK.
REQ-021 In WALK, entry stop condition: idx==NUM_HEADERS or len[idx]==0 -> go to DONE, err<=0.
REQ-022 In WALK, else compute sum = offset + len[idx] in ADDR_WIDTH+1 bits; if sum > latched pkt_len -> go to DONE, err<=1, no hdr_valid.
REQ-023 In WALK, else: next cycle hdr_valid=1, hdr_idx=idx, hdr_addr_o=offset; offset<=sum[ADDR_WIDTH-1:0]; idx<=idx+1; cnt<=cnt+1; remain in WALK.
REQ-024 A header ending exactly at pkt_len (sum == pkt_len) SHALL be emitted, not an error.
REQ-025 idx SHALL be IDX_WIDTH+1 bits so idx==NUM_HEADERS is representable without wrap.
REQ-026 DONE SHALL last exactly one cycle: done=1, err as decided, hdr_cnt=cnt; then IDLE.
REQ-027 hdr_valid, done SHALL be registered, one cycle high per event; hdr_addr_o, hdr_idx, hdr_cnt, err SHALL hold their last values otherwise.
REQ-028 cfg_we SHALL write len[cfg_idx]<=cfg_len only when state is IDLE; ignored in WALK and DONE.
REQ-029 cfg_we and accept at the same edge: write SHALL take effect and the walk SHALL use the updated entry.
REQ-030 pkt_valid while not ready SHALL be ignored; pkt_len changes during a walk SHALL not affect it.
REQ-031 Latency: first hdr_valid two cycles after accept edge; done at accept + (emitted headers) + 2 cycles.

Reset
REQ-032 On rst high, immediately (asynchronously): state IDLE, pkt_ready=1, hdr_valid=0, done=0, err=0, hdr_idx=0, hdr_addr_o=0, hdr_cnt=0, offset/idx/cnt=0.
REQ-033 Reset SHALL load table defaults len[0]=14 (Ethernet), len[1]=20 (IPv4), all other entries 0.
REQ-034 Reset mid-walk SHALL abort without emitting done; walk state and config writes are lost.

Verification
REQ-035 Defaults, pkt_len=64 accepted at edge 0 -> hdr_valid idx0 addr0 at cycle 2, idx1 addr14 at cycle 3, done at cycle 4, hdr_cnt=2, err=0, pkt_ready=1 at cycle 5.
REQ-036 Defaults, pkt_len=30 -> hdr_valid idx0 addr0 only; done with err=1, hdr_cnt=1.
REQ-037 Defaults, pkt_len=34 -> both headers emitted (34 == 14+20), err=0, hdr_cnt=2.
REQ-038 Write len[2]=8, len[3]=4 in IDLE, pkt_len=100 -> addrs 0,14,34,42; hdr_cnt=4 (idx==NUM_HEADERS stop), err=0.
REQ-039 cfg_we len[0]=0 during WALK -> ignored, walk unchanged; cfg_we len[0]=0 in IDLE then packet -> done next-but-one cycle, hdr_cnt=0, no hdr_valid.
REQ-040 Assert rst mid-walk after first hdr_valid -> outputs zero immediately, no done; after release, table back to 14/20/0/0 and new packet parses per REQ-035.

Source files
------------

// File: rtl/parse_ctrl_if.sv
// Packet-parse controller bus: config writes, packet handoff, header results.
// master drives packets/config, slave is the controller.
interface parse_ctrl_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int LEN_WIDTH   = 8,
  parameter int NUM_HEADERS = 4
);
  localparam int IDX_WIDTH = $clog2(NUM_HEADERS);

  logic                  cfg_we;
  logic [IDX_WIDTH-1:0]  cfg_idx;
  logic [LEN_WIDTH-1:0]  cfg_len;
  logic                  pkt_valid;
  logic [ADDR_WIDTH-1:0] pkt_len;
  logic                  pkt_ready;
  logic                  hdr_valid;
  logic [IDX_WIDTH-1:0]  hdr_idx;
  logic [ADDR_WIDTH-1:0] hdr_addr_o;
  logic                  done;
  logic                  err;
  logic [IDX_WIDTH:0]    hdr_cnt;

  modport master (
    output cfg_we, cfg_idx, cfg_len, pkt_valid, pkt_len,
    input  pkt_ready, hdr_valid, hdr_idx, hdr_addr_o,
    input  done, err, hdr_cnt
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_len, pkt_valid, pkt_len,
    output pkt_ready, hdr_valid, hdr_idx, hdr_addr_o,
    output done, err, hdr_cnt
  );
endinterface

// File: rtl/parse_ctrl.sv
// Header walker: steps through a table of header lengths and reports
// each header offset inside the packet until the table or packet ends.
module parse_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int LEN_WIDTH   = 8,
  parameter int NUM_HEADERS = 4
) (
  input logic         clk,
  input logic         rst,
  parse_ctrl_if.slave bus
);
  localparam int IDX_WIDTH = $clog2(NUM_HEADERS);

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t                state;
  logic [LEN_WIDTH-1:0]  len_tbl [NUM_HEADERS];
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] offset;
  logic [IDX_WIDTH:0]    idx;
  logic [IDX_WIDTH:0]    cnt;

  logic                  ready_q;
  logic                  hv_q;
  logic [IDX_WIDTH-1:0]  hidx_q;
  logic [ADDR_WIDTH-1:0] haddr_q;
  logic                  done_q;
  logic                  err_q;
  logic [IDX_WIDTH:0]    hcnt_q;

  logic                  at_end;
  logic [LEN_WIDTH-1:0]  cur_len;
  logic [ADDR_WIDTH:0]   sum;

  assign at_end = (idx == (IDX_WIDTH+1)'(NUM_HEADERS));

  always_comb begin
    cur_len = '0;
    if (!at_end) cur_len = len_tbl[idx[IDX_WIDTH-1:0]];
  end

  // one extra bit so an overrun past the top of the address range is seen
  assign sum = {1'b0, offset} + (ADDR_WIDTH+1)'(cur_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_HEADERS; i++) len_tbl[i] <= '0;
      len_tbl[0] <= LEN_WIDTH'(14);
      if (NUM_HEADERS > 1) len_tbl[1] <= LEN_WIDTH'(20);
    end else if (bus.cfg_we && state == IDLE) begin
      len_tbl[bus.cfg_idx] <= bus.cfg_len;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      hv_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hidx_q  <= '0;
      haddr_q <= '0;
      hcnt_q  <= '0;
      len_q   <= '0;
      offset  <= '0;
      idx     <= '0;
      cnt     <= '0;
    end else begin
      hv_q   <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.pkt_valid) begin
            len_q   <= bus.pkt_len;
            offset  <= '0;
            idx     <= '0;
            cnt     <= '0;
            ready_q <= 1'b0;
            state   <= WALK;
          end
        end
        WALK: begin
          if (at_end || cur_len == '0) begin
            state  <= DONE;
            done_q <= 1'b1;
            err_q  <= 1'b0;
            hcnt_q <= cnt;
          end else if (sum > {1'b0, len_q}) begin
            state  <= DONE;
            done_q <= 1'b1;
            err_q  <= 1'b1;
            hcnt_q <= cnt;
          end else begin
            hv_q    <= 1'b1;
            hidx_q  <= idx[IDX_WIDTH-1:0];
            haddr_q <= offset;
            offset  <= sum[ADDR_WIDTH-1:0];
            idx     <= idx + 1'b1;
            cnt     <= cnt + 1'b1;
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.pkt_ready  = ready_q;
  assign bus.hdr_valid  = hv_q;
  assign bus.hdr_idx    = hidx_q;
  assign bus.hdr_addr_o = haddr_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.hdr_cnt    = hcnt_q;
endmodule

// File: tb/tb_parse_ctrl.sv
// Directed vector bench for parse_ctrl: table-driven packet walks plus
// reset, config-during-walk and same-edge config sequences.
module tb_parse_ctrl;
  logic clk;
  logic rst;

  parse_ctrl_if #(.ADDR_WIDTH(16), .LEN_WIDTH(8), .NUM_HEADERS(4)) bus ();

  parse_ctrl #(.ADDR_WIDTH(16), .LEN_WIDTH(8), .NUM_HEADERS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit              wr;
    logic [3:0][7:0] tbl;
    int              len;
    int              nh;
    logic [3:0][15:0] addr;
    bit              err;
  } vec_t;

  vec_t vecs [11];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit wr, input int t0, input int t1,
                              input int t2, input int t3, input int len,
                              input int nh, input int a0, input int a1,
                              input int a2, input int a3, input bit err);
    vec_t v;
    v.wr   = wr;
    v.tbl  = {8'(t3), 8'(t2), 8'(t1), 8'(t0)};
    v.len  = len;
    v.nh   = nh;
    v.addr = {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    v.err  = err;
    return v;
  endfunction

  task automatic cfg_write(input int i, input int v);
    @(negedge clk);
    bus.cfg_we  = 1'b1;
    bus.cfg_idx = 2'(i);
    bus.cfg_len = 8'(v);
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
  endtask

  task automatic run_check(input string nm, input int len, input int nh,
                           input logic [3:0][15:0] ea, input bit eerr,
                           input bit same_wr, input int same_len,
                           input bit mid_wr);
    int  got;
    bit  seen;
    got  = 0;
    seen = 1'b0;
    @(negedge clk);
    chk({nm, " ready_before"}, int'(bus.pkt_ready), 1);
    bus.pkt_valid = 1'b1;
    bus.pkt_len   = 16'(len);
    if (same_wr) begin
      bus.cfg_we  = 1'b1;
      bus.cfg_idx = 2'd0;
      bus.cfg_len = 8'(same_len);
    end
    @(posedge clk);
    #1;
    bus.pkt_valid = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.pkt_len   = 16'hFFFF;
    for (int k = 1; k <= 30 && !seen; k++) begin
      @(negedge clk);
      if (mid_wr && k == 1) begin
        bus.cfg_we    = 1'b1;
        bus.cfg_idx   = 2'd0;
        bus.cfg_len   = 8'd0;
        bus.pkt_valid = 1'b1;
        bus.pkt_len   = 16'd5;
      end
      if (mid_wr && k == 2) begin
        bus.cfg_we    = 1'b0;
        bus.pkt_valid = 1'b0;
      end
      if (bus.hdr_valid) begin
        if (got < 4) begin
          chk($sformatf("%s hdr%0d_idx", nm, got), int'(bus.hdr_idx), got);
          chk($sformatf("%s hdr%0d_addr", nm, got),
              int'(bus.hdr_addr_o), int'(ea[got]));
          chk($sformatf("%s hdr%0d_cycle", nm, got), k, got + 2);
        end
        got++;
      end
      if (bus.done) begin
        seen = 1'b1;
        chk({nm, " done_cycle"}, k, nh + 2);
        chk({nm, " hdr_cnt"}, int'(bus.hdr_cnt), nh);
        chk({nm, " err"}, int'(bus.err), int'(eerr));
      end
    end
    chk({nm, " done_seen"}, int'(seen), 1);
    chk({nm, " num_hdrs"}, got, nh);
    @(negedge clk);
    chk({nm, " ready_after"}, int'(bus.pkt_ready), 1);
    chk({nm, " done_pulse"}, int'(bus.done), 0);
    chk({nm, " err_hold"}, int'(bus.err), int'(eerr));
    if (nh > 0)
      chk({nm, " addr_hold"}, int'(bus.hdr_addr_o), int'(ea[nh-1]));
  endtask

  initial begin
    bit seen;
    vecs[0]  = mk(0, 0, 0, 0, 0, 64, 2, 0, 14, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 30, 1, 0, 0, 0, 0, 1);
    vecs[2]  = mk(0, 0, 0, 0, 0, 34, 2, 0, 14, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 33, 1, 0, 0, 0, 0, 1);
    vecs[4]  = mk(0, 0, 0, 0, 0, 14, 1, 0, 0, 0, 0, 1);
    vecs[5]  = mk(0, 0, 0, 0, 0, 13, 0, 0, 0, 0, 0, 1);
    vecs[6]  = mk(1, 14, 20, 8, 4, 100, 4, 0, 14, 34, 42, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 46, 4, 0, 14, 34, 42, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 45, 3, 0, 14, 34, 0, 1);
    vecs[9]  = mk(1, 0, 20, 8, 4, 100, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(1, 14, 20, 0, 0, 34, 2, 0, 14, 0, 0, 0);

    rst           = 1'b1;
    bus.cfg_we    = 1'b0;
    bus.cfg_idx   = '0;
    bus.cfg_len   = '0;
    bus.pkt_valid = 1'b0;
    bus.pkt_len   = '0;
    repeat (2) @(negedge clk);
    chk("rst ready", int'(bus.pkt_ready), 1);
    chk("rst hdr_valid", int'(bus.hdr_valid), 0);
    chk("rst done", int'(bus.done), 0);
    chk("rst err", int'(bus.err), 0);
    chk("rst hdr_idx", int'(bus.hdr_idx), 0);
    chk("rst hdr_addr", int'(bus.hdr_addr_o), 0);
    chk("rst hdr_cnt", int'(bus.hdr_cnt), 0);
    rst = 1'b0;

    for (int v = 0; v < 11; v++) begin
      if (vecs[v].wr)
        for (int i = 0; i < 4; i++) cfg_write(i, int'(vecs[v].tbl[i]));
      run_check($sformatf("vec%0d", v), vecs[v].len, vecs[v].nh,
                vecs[v].addr, vecs[v].err, 1'b0, 0, 1'b0);
    end

    run_check("mid_cfg", 64, 2, {16'd0, 16'd0, 16'd14, 16'd0}, 1'b0,
              1'b0, 0, 1'b1);
    run_check("mid_cfg_after", 64, 2, {16'd0, 16'd0, 16'd14, 16'd0}, 1'b0,
              1'b0, 0, 1'b0);
    run_check("same_edge_cfg", 64, 2, {16'd0, 16'd0, 16'd10, 16'd0}, 1'b0,
              1'b1, 10, 1'b0);

    @(negedge clk);
    bus.pkt_valid = 1'b1;
    bus.pkt_len   = 16'd64;
    @(posedge clk);
    #1;
    bus.pkt_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.hdr_valid && bus.hdr_idx == 2'd1) seen = 1'b1;
    end
    chk("rst_mid second_hdr_seen", int'(seen), 1);
    chk("rst_mid addr_before", int'(bus.hdr_addr_o), 10);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid hdr_valid", int'(bus.hdr_valid), 0);
    chk("rst_mid hdr_addr", int'(bus.hdr_addr_o), 0);
    chk("rst_mid hdr_idx", int'(bus.hdr_idx), 0);
    chk("rst_mid ready", int'(bus.pkt_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.done || bus.hdr_valid) seen = 1'b1;
    end
    chk("rst_mid no_done", int'(seen), 0);
    run_check("post_rst", 64, 2, {16'd0, 16'd0, 16'd14, 16'd0}, 1'b0,
              1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
